// File: rtl/mem_access_responder.sv
// mem_access_responder
//   Memory-side responder that owns a (2**ADDR_WIDTH) x DATA_WIDTH array and
//   services single requests from the Control unit. It captures address and
//   write data on accept, then inserts WAIT_STATES wait cycles. After that it
//   does exactly one read or write and returns a one-cycle ready strobe.
//
// Handshake: a request is Mem_enable512x32=1 with exactly one of
//   Mem_Read/Mem_Write. The responder accepts it only in IDLE, and accepting
//   commits it. Mem_busy is high from accept until the FSM returns to IDLE.
//   Mem_ready pulses once when the access completes, and Mem_rdata is valid
//   in that same cycle. Mem_error pulses once instead for a Read+Write
//   request. The FSM does not return to IDLE while Control still holds the
//   request, so a held request is not re-issued.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   Mem_enable512x32  request qualifier
//   Mem_Read/Write    operation select
//   MAR_addr          address (captured on accept)
//   MDR_wdata         write data (captured on accept)
//   Mem_rdata         registered read data, held until the next read
//   Mem_ready         one-cycle completion strobe
//   Mem_busy          request in flight
//   Mem_error         one-cycle strobe for an illegal request
module mem_access_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Mem_enable512x32,
  input  logic                  Mem_Read,
  input  logic                  Mem_Write,
  input  logic [ADDR_WIDTH-1:0] MAR_addr,
  input  logic [DATA_WIDTH-1:0] MDR_wdata,
  output logic [DATA_WIDTH-1:0] Mem_rdata,
  output logic                  Mem_ready,
  output logic                  Mem_busy,
  output logic                  Mem_error
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // The counter is loaded with WAIT_STATES-1 so that the last wait cycle is
  // the one in which it reads zero.
  localparam logic [2:0] CNT_LOAD = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_ACCESS  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic                    op_write_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic req_valid, req_illegal, req_present;
  logic latch_req, mem_we, mem_re, ready_d, error_d;

  assign req_valid   = Mem_enable512x32 & (Mem_Read ^ Mem_Write);
  assign req_illegal = Mem_enable512x32 & Mem_Read & Mem_Write;
  assign req_present = Mem_enable512x32 & (Mem_Read | Mem_Write);

  // State register plus the registers that are captured or updated alongside it
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      Mem_rdata  <= '0;
      Mem_ready  <= 1'b0;
      Mem_error  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      Mem_ready <= ready_d;
      Mem_error <= error_d;
      if (latch_req) begin
        op_write_q <= Mem_Write;
        addr_q     <= MAR_addr;
        wdata_q    <= MDR_wdata;
      end
      if (mem_re) begin
        Mem_rdata <= mem[addr_q];
      end
    end
  end

  // The array itself is not reset. Reset still blocks a write that would
  // otherwise commit on the same edge.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[addr_q] <= wdata_q;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
          cnt_d   = CNT_LOAD;
        end else if (req_illegal) begin
          state_d = S_RELEASE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_ACCESS: state_d = S_RELEASE;
      S_RELEASE: begin
        // Stay here while Control still holds a request, so it is not re-issued.
        if (!req_present) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath-control logic
  always_comb begin
    latch_req = (state_q == S_IDLE) && req_valid;
    mem_we    = (state_q == S_ACCESS) && op_write_q;
    mem_re    = (state_q == S_ACCESS) && !op_write_q;
    ready_d   = (state_q == S_ACCESS);
    error_d   = (state_q == S_IDLE) && req_illegal;
  end

  assign Mem_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_access_responder.sv
// Bench for mem_access_responder. There are three instances with WAIT_STATES
// set to 1, 0 and 3, and each has its own inputs and reset. A table of
// transactions holds expected latency, strobe counts, release cycle and read
// data, all worked out by hand. Sequences written out step by step cover the
// idle no-op case and reset arriving mid-write.
module tb_mem_access_responder;

  localparam int NU = 3;
  localparam int WS [NU] = '{1, 0, 3};

  logic        clk = 1'b0;
  logic        rst   [NU];
  logic        en    [NU];
  logic        rd    [NU];
  logic        wr    [NU];
  logic [8:0]  addr  [NU];
  logic [31:0] wdata [NU];
  logic [31:0] rdata [NU];
  logic        ready [NU];
  logic        busy  [NU];
  logic        error [NU];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    mem_access_responder #(
      .DATA_WIDTH(32), .ADDR_WIDTH(9), .WAIT_STATES(WS[g])
    ) dut (
      .clk(clk), .reset(rst[g]),
      .Mem_enable512x32(en[g]), .Mem_Read(rd[g]), .Mem_Write(wr[g]),
      .MAR_addr(addr[g]), .MDR_wdata(wdata[g]),
      .Mem_rdata(rdata[g]), .Mem_ready(ready[g]),
      .Mem_busy(busy[g]), .Mem_error(error[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Sends one request to unit u and holds it for `hold` edges, counting the
  // accept edge. When the request drops, address and data are inverted so that
  // any use of them after accept shows up. The task reports the edge offset of
  // the first ready pulse, the number of ready and error pulses, and the edge
  // offset at which busy falls. Offsets are counted from the accept edge (0).
  task automatic xact(input int u, input logic e, input logic r, input logic w,
                      input logic [8:0] a, input logic [31:0] d, input int hold,
                      output int lat, output int nrdy, output int nerr,
                      output int idle_at);
    lat = -1; nrdy = 0; nerr = 0; idle_at = -1;
    en[u] = e; rd[u] = r; wr[u] = w; addr[u] = a; wdata[u] = d;
    for (int j = 0; j < 40; j++) begin
      tick();
      if (ready[u]) begin
        nrdy++;
        if (lat < 0) lat = j;
      end
      if (error[u]) nerr++;
      if (j == hold - 1) begin
        en[u] = 1'b0; rd[u] = 1'b0; wr[u] = 1'b0;
        addr[u] = ~a; wdata[u] = ~d;
      end
      if (!busy[u]) begin
        idle_at = j;
        break;
      end
    end
    // one extra cycle to catch a stray strobe
    tick();
    if (ready[u]) nrdy++;
    if (error[u]) nerr++;
  endtask

  typedef struct {
    int          u;
    logic        e, r, w;
    logic [8:0]  a;
    logic [31:0] d;
    int          hold;
    int          exp_lat, exp_nrdy, exp_nerr, exp_idle;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  initial begin
    int lat, nrdy, nerr, idle_at, nbusy, nrdy_seen;

    // u0: WAIT_STATES=1 (ready at +2, idle at +3 for a short request)
    vecs[0]  = '{0, 1, 0, 1, 9'h005, 32'hDEADBEEF, 1,  2, 1, 0, 3, 32'h00000000};
    vecs[1]  = '{0, 1, 1, 0, 9'h005, 32'h00000000, 1,  2, 1, 0, 3, 32'hDEADBEEF};
    // u1: WAIT_STATES=0 (ready at +1, idle at +2)
    vecs[2]  = '{1, 1, 0, 1, 9'h1FF, 32'h00000003, 1,  1, 1, 0, 2, 32'h00000000};
    vecs[3]  = '{1, 1, 1, 0, 9'h1FF, 32'h00000000, 1,  1, 1, 0, 2, 32'h00000003};
    // held read for 6 edges: one ready pulse, release at the 6th edge
    vecs[4]  = '{0, 1, 1, 0, 9'h005, 32'h00000000, 6,  2, 1, 0, 6, 32'hDEADBEEF};
    // illegal request: error at +0, no ready, rdata unchanged
    vecs[5]  = '{0, 1, 1, 1, 9'h005, 32'h0BADF00D, 1, -1, 0, 1, 1, 32'hDEADBEEF};
    vecs[6]  = '{0, 1, 1, 0, 9'h005, 32'h00000000, 1,  2, 1, 0, 3, 32'hDEADBEEF};
    // address/data change after accept: the dropped values point at 0x1DF
    vecs[7]  = '{0, 1, 0, 1, 9'h1DF, 32'h77777777, 1,  2, 1, 0, 3, 32'hDEADBEEF};
    vecs[8]  = '{0, 1, 0, 1, 9'h020, 32'hCAFEF00D, 1,  2, 1, 0, 3, 32'hDEADBEEF};
    vecs[9]  = '{0, 1, 1, 0, 9'h020, 32'h00000000, 1,  2, 1, 0, 3, 32'hCAFEF00D};
    vecs[10] = '{0, 1, 1, 0, 9'h1DF, 32'h00000000, 1,  2, 1, 0, 3, 32'h77777777};
    // u2: WAIT_STATES=3 (ready at +4, idle at +5)
    vecs[11] = '{2, 1, 0, 1, 9'h010, 32'hAAAAAAAA, 1,  4, 1, 0, 5, 32'h00000000};
    vecs[12] = '{2, 1, 1, 0, 9'h010, 32'h00000000, 1,  4, 1, 0, 5, 32'hAAAAAAAA};
    // u1 held read and held illegal request
    vecs[13] = '{1, 1, 1, 0, 9'h1FF, 32'h00000000, 4,  1, 1, 0, 4, 32'h00000003};
    vecs[14] = '{1, 1, 1, 1, 9'h1FF, 32'h00000000, 3, -1, 0, 1, 3, 32'h00000003};

    for (int u = 0; u < NU; u++) begin
      rst[u] = 1'b1; en[u] = 1'b0; rd[u] = 1'b0; wr[u] = 1'b0;
      addr[u] = '0; wdata[u] = '0;
    end
    tick(); tick();
    for (int u = 0; u < NU; u++) begin
      chk($sformatf("u%0d reset rdata", u), rdata[u], 32'h0);
      chk($sformatf("u%0d reset ready", u), 32'(ready[u]), 32'h0);
      chk($sformatf("u%0d reset busy", u), 32'(busy[u]), 32'h0);
      chk($sformatf("u%0d reset error", u), 32'(error[u]), 32'h0);
      rst[u] = 1'b0;
    end
    tick();

    for (int i = 0; i < NV; i++) begin
      xact(vecs[i].u, vecs[i].e, vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d,
           vecs[i].hold, lat, nrdy, nerr, idle_at);
      chk($sformatf("v%0d ready_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d ready_pulses", i), 32'(nrdy), 32'(vecs[i].exp_nrdy));
      chk($sformatf("v%0d error_pulses", i), 32'(nerr), 32'(vecs[i].exp_nerr));
      chk($sformatf("v%0d busy_release", i), 32'(idle_at), 32'(vecs[i].exp_idle));
      chk($sformatf("v%0d rdata", i), rdata[vecs[i].u], vecs[i].exp_rdata);
      tick();
    end

    // Enable with neither Read nor Write set: nothing should happen.
    nbusy = 0; nrdy_seen = 0;
    en[0] = 1'b1; rd[0] = 1'b0; wr[0] = 1'b0; addr[0] = 9'h005;
    for (int j = 0; j < 4; j++) begin
      tick();
      if (busy[0]) nbusy++;
      if (ready[0] || error[0]) nrdy_seen++;
    end
    en[0] = 1'b0;
    chk("noop busy_cycles", 32'(nbusy), 32'h0);
    chk("noop strobes", 32'(nrdy_seen), 32'h0);
    tick();

    // Reset during WAIT on u2 (WAIT_STATES=3): the write of 0x12345678 must not land.
    en[2] = 1'b1; wr[2] = 1'b1; rd[2] = 1'b0; addr[2] = 9'h010; wdata[2] = 32'h12345678;
    tick();                                  // accept edge
    chk("midrst busy_after_accept", 32'(busy[2]), 32'h1);
    en[2] = 1'b0; wr[2] = 1'b0;
    tick();                                  // still waiting
    rst[2] = 1'b1;
    tick();                                  // reset edge
    chk("midrst busy", 32'(busy[2]), 32'h0);
    chk("midrst ready", 32'(ready[2]), 32'h0);
    chk("midrst error", 32'(error[2]), 32'h0);
    chk("midrst rdata", rdata[2], 32'h0);
    rst[2] = 1'b0;
    nrdy_seen = 0; nbusy = 0;
    for (int j = 0; j < 5; j++) begin
      tick();
      if (ready[2]) nrdy_seen++;
      if (busy[2]) nbusy++;
    end
    chk("midrst no_ready_after", 32'(nrdy_seen), 32'h0);
    chk("midrst stays_idle", 32'(nbusy), 32'h0);
    xact(2, 1'b1, 1'b1, 1'b0, 9'h010, 32'h0, 1, lat, nrdy, nerr, idle_at);
    chk("midrst reread latency", 32'(lat), 32'd4);
    chk("midrst reread rdata", rdata[2], 32'hAAAAAAAA);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
